ddr3_rdlvl_ctrl: RTL and testbench

Read-levelling controller for the DDR3 PHY. It selects at runtime which of the eight IDES4 word-alignment settings (the 3-bit capture shift) makes read data line up with beat 0 of a burst. For each shift it applies the shift, issues calibration reads through the memory controller and compares each returned BL8 burst against a fixed beat pattern. It then reports the per-shift pass mask and the chosen shift, and drives that shift to the capture mux until the next calibration run.

---
 rtl/ddr3_rdlvl_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_ddr3_rdlvl_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_rdlvl_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rdlvl_ctrl
// Purpose  : DDR3 read-levelling controller. It sweeps the eight IDES4
//            word-alignment shifts. For each shift it waits for the capture
//            path to settle, then issues TRIES calibration reads. Every BL8
//            burst that comes back is compared against PATTERN. At the end it
//            reports a per-shift pass mask and drives the chosen shift to the
//            capture mux.
// Ports    : clock/reset_n       - PCLK and async active-low reset
//            start               - one-cycle request for a calibration run
//            busy/done/fail      - run status (fail is qualified by done)
//            shift_sel           - capture shift driven to the IOB mux
//            pass_mask           - bit s set when shift s passed
//            rd_req/rd_ack       - calibration read handshake
//            rd_valid/rd_data    - captured words, Q1 in the upper half
// Config   : RDLVL_CENTRE_EN - when defined, the chosen shift is the centre
//            of the longest run of passing shifts. When undefined, it is the
//            lowest passing shift.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_rdlvl_ctrl #(
    parameter int         WIDTH   = 16,
    parameter logic [7:0] PATTERN = 8'h1B,
    parameter int         TRIES   = 2,
    parameter int         SETTLE  = 4,
    parameter int         TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [2:0]         shift_sel,
    output logic [7:0]         pass_mask,
    output logic               rd_req,
    input  logic               rd_ack,
    input  logic               rd_valid,
    input  logic [2*WIDTH-1:0] rd_data
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int TRY_W = $clog2(TRIES + 1);
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [2:0]       shift_q, shift_d;
    logic [7:0]       pass_q,  pass_d;
    logic             done_q,  done_d;
    logic             fail_q,  fail_d;
    logic             tfail_q, tfail_d;
    logic [1:0]       word_q,  word_d;
    logic [TMO_W-1:0] tmo_q,   tmo_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [SET_W-1:0] settle_q, settle_d;
`ifdef RDLVL_CENTRE_EN
    logic             last_q,  last_d;   // second NEXT cycle for shift 7
`endif

    // Word k of the burst: beat 2k+1 in the upper half, beat 2k in the lower half.
    function automatic logic [2*WIDTH-1:0] exp_word(input logic [1:0] k);
        logic b_hi;
        logic b_lo;
        b_hi = PATTERN[{k, 1'b1}];
        b_lo = PATTERN[{k, 1'b0}];
        return {{WIDTH{b_hi}}, {WIDTH{b_lo}}};
    endfunction

`ifdef RDLVL_CENTRE_EN
    // The update fires only when a run becomes strictly longer, so the lower
    // of two equal-length runs is kept.
    function automatic logic [2:0] centre_of(input logic [7:0] m);
        logic [3:0] run_len;
        logic [3:0] best_len;
        logic [2:0] run_start;
        logic [2:0] best_start;
        run_len    = 4'd0;
        best_len   = 4'd0;
        run_start  = 3'd0;
        best_start = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (run_len == 4'd0) run_start = 3'(i);
                run_len = run_len + 4'd1;
                if (run_len > best_len) begin
                    best_len   = run_len;
                    best_start = run_start;
                end
            end else begin
                run_len = 4'd0;
            end
        end
        return best_start + 3'((best_len - 4'd1) >> 1);
    endfunction
`else
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        pass_d   = pass_q;
        done_d   = done_q;
        fail_d   = fail_q;
        tfail_d  = tfail_q;
        word_d   = word_q;
        tmo_d    = tmo_q;
        tries_d  = tries_q;
        settle_d = settle_q;
`ifdef RDLVL_CENTRE_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pass_d   = 8'd0;
                    done_d   = 1'b0;
                    fail_d   = 1'b0;
                    shift_d  = 3'd0;
                    tfail_d  = 1'b0;
                    tries_d  = TRY_W'(TRIES);
                    settle_d = '0;
`ifdef RDLVL_CENTRE_EN
                    last_d   = 1'b0;
`endif
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (settle_q == SET_W'(SETTLE - 1)) state_d = S_REQ;
                else settle_d = settle_q + SET_W'(1);
            end
            S_REQ: begin
                if (rd_ack) begin
                    word_d  = 2'd0;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rd_valid && (rd_data != exp_word(word_q))) tfail_d = 1'b1;
                // Word 3 arriving on the last timeout cycle still completes the read.
                if (rd_valid && (word_q == 2'd3)) begin
                    tries_d = tries_q - TRY_W'(1);
                    state_d = (tries_d != '0) ? S_REQ : S_NEXT;
                end else begin
                    if (rd_valid) word_d = word_q + 2'd1;
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        tfail_d = 1'b1;
                        state_d = S_NEXT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            S_NEXT: begin
                pass_d[shift_q] = ~tfail_q;
                if (shift_q != 3'd7) begin
                    shift_d  = shift_q + 3'd1;
                    tfail_d  = 1'b0;
                    tries_d  = TRY_W'(TRIES);
                    settle_d = '0;
                    state_d  = S_SETUP;
                end else begin
`ifdef RDLVL_CENTRE_EN
                    // First pass commits bit 7; the centre is chosen from the
                    // registered mask on the following cycle.
                    if (!last_q) begin
                        last_d = 1'b1;
                    end else begin
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        fail_d  = (pass_q == 8'd0);
                        shift_d = (pass_q == 8'd0) ? 3'd0 : centre_of(pass_q);
                        state_d = S_DONE;
                    end
`else
                    done_d  = 1'b1;
                    fail_d  = (pass_d == 8'd0);
                    shift_d = lowest_set(pass_d);
                    state_d = S_DONE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            shift_q  <= 3'd0;
            pass_q   <= 8'd0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            tfail_q  <= 1'b0;
            word_q   <= 2'd0;
            tmo_q    <= '0;
            tries_q  <= '0;
            settle_q <= '0;
`ifdef RDLVL_CENTRE_EN
            last_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            tfail_q  <= tfail_d;
            word_q   <= word_d;
            tmo_q    <= tmo_d;
            tries_q  <= tries_d;
            settle_q <= settle_d;
`ifdef RDLVL_CENTRE_EN
            last_q   <= last_d;
`endif
        end
    end

    // Decoded straight from the state flop so that reset clears rd_req immediately.
    assign rd_req    = (state_q == S_REQ);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = done_q;
    assign fail      = fail_q;
    assign shift_sel = shift_q;
    assign pass_mask = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_rdlvl_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_rdlvl_ctrl
// Purpose  : Self-checking bench for ddr3_rdlvl_ctrl. A memory model answers
//            read requests with randomised ack delays. It returns correct
//            bursts only for the shifts marked good in each vector. Results
//            are compared against a reference selection model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_rdlvl_ctrl;

    localparam int         WIDTH   = 16;
    localparam logic [7:0] PATTERN = 8'h1B;
    localparam int         TRIES   = 2;
    localparam int         SETTLE  = 4;
    localparam int         TIMEOUT = 64;
    localparam int         NONE    = 8;
`ifdef RDLVL_CENTRE_EN
    localparam int C_5C = 3;
    localparam int C_DF = 2;
`else
    localparam int C_5C = 2;
    localparam int C_DF = 0;
`endif

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               busy, done, fail, rd_req;
    logic [2:0]         shift_sel;
    logic [7:0]         pass_mask;
    logic               rd_ack = 1'b0;
    logic               rd_valid = 1'b0;
    logic [2*WIDTH-1:0] rd_data = '0;

    ddr3_rdlvl_ctrl #(
        .WIDTH(WIDTH), .PATTERN(PATTERN), .TRIES(TRIES),
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy),
        .done(done), .fail(fail), .shift_sel(shift_sel), .pass_mask(pass_mask),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int k);
        logic [7:0] p;
        p = PATTERN;
        return {{WIDTH{p[2*k+1]}}, {WIDTH{p[2*k]}}};
    endfunction

    // Reference selection computed by enumerating candidate runs.
    function automatic int model_choice(input logic [7:0] m);
        int best_len;
        int best_s;
        bool_ok: begin end
        if (m == 8'd0) return 0;
`ifdef RDLVL_CENTRE_EN
        best_len = 0;
        best_s   = 0;
        for (int s = 0; s < 8; s++) begin
            for (int e = s; e < 8; e++) begin
                bit all;
                all = 1'b1;
                for (int j = s; j <= e; j++) if (!m[j]) all = 1'b0;
                if (all && (e - s + 1) > best_len) begin
                    best_len = e - s + 1;
                    best_s   = s;
                end
            end
        end
        return best_s + (best_len - 1) / 2;
`else
        best_len = 0;
        best_s   = 0;
        for (int i = 7; i >= 0; i--) if (m[i]) best_s = i;
        return best_s + best_len;
`endif
    endfunction

    typedef struct {
        logic [7:0] good;
        int         withhold;
        int         maxd;
        logic [7:0] exp_mask;
        int         exp_shift;
        logic       exp_fail;
        int         exp_hs;
    } vec_t;

    vec_t vecs[8];

    // One calibration run with the memory model attached. If reset_after_hs
    // matches a handshake count, reset is pulsed in the WAIT that follows it.
    task automatic run_cal(input logic [7:0] good, input int withhold, input int maxd,
                           input int reset_after_hs, input bit check_timing,
                           output int hs, output bit aborted);
        int  k;
        int  budget;
        int  d;
        int  c;
        int  t;
        bit  seen;
        logic [2:0] sh;
        logic [31:0] bad;
        hs = 0;
        aborted = 1'b0;
        seen = 1'b0;
        budget = 20000;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        k = 1;
        while (!done && !aborted && budget > 0) begin
            @(negedge clock);
            budget--;
            k++;
            if (rd_req) begin
                if (check_timing && !seen) chk("first_req_edge", k, SETTLE + 1);
                seen = 1'b1;
                d = $urandom_range(maxd, 0);
                repeat (d) @(negedge clock);
                rd_ack = 1'b1;
                sh = shift_sel;
                c = cyc;
                @(negedge clock);
                rd_ack = 1'b0;
                hs++;
                if (hs == reset_after_hs) begin
                    #2 reset_n = 1'b0;
                    #1;
                    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
                    chk("rst_outputs", {busy, done, fail, shift_sel, pass_mask}, 32'd0);
                    @(negedge clock) reset_n = 1'b1;
                    aborted = 1'b1;
                end else if (sh == withhold) begin
                    t = 0;
                    while (shift_sel == sh && t < TIMEOUT + 10) begin
                        @(negedge clock);
                        t++;
                    end
                    chk("timeout_latency", cyc - c, TIMEOUT + 2);
                    chk("timeout_mask_bit", {31'd0, pass_mask[sh]}, 32'd0);
                    // Late words land in SETUP of the next shift and must be ignored.
                    for (int w = 0; w < 4; w++) begin
                        rd_valid = 1'b1;
                        rd_data  = model_word(w);
                        @(negedge clock);
                    end
                    rd_valid = 1'b0;
                    rd_data  = '0;
                end else begin
                    bad = $urandom | 32'd1;
                    for (int w = 0; w < 4; w++) begin
                        rd_valid = 1'b1;
                        rd_data  = model_word(w) ^ (good[sh] ? 32'd0 : bad);
                        @(negedge clock);
                    end
                    rd_valid = 1'b0;
                    rd_data  = '0;
                end
            end
        end
        if (budget <= 0) chk("run_cycle_budget", 32'd0, 32'd1);
    endtask

    task automatic check_result(input vec_t v, input int hs, input int idx);
        chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_fail", idx), {31'd0, fail}, {31'd0, v.exp_fail});
        chk($sformatf("v%0d_mask", idx), {24'd0, pass_mask}, {24'd0, v.exp_mask});
        chk($sformatf("v%0d_shift", idx), {29'd0, shift_sel}, v.exp_shift);
        chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d_handshakes", idx), hs, v.exp_hs);
        repeat (3) @(negedge clock);
        chk($sformatf("v%0d_done_held", idx), {31'd0, done}, 32'd1);
    endtask

    initial begin
        int  hs;
        bit  ab;
        vec_t v;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle_outputs", {busy, done, fail, rd_req, shift_sel, pass_mask}, 32'd0);
        end

        vecs[0] = '{8'h08, NONE, 0, 8'h08, 3,    1'b0, 8 * TRIES};
        vecs[1] = '{8'h5C, NONE, 2, 8'h5C, C_5C, 1'b0, 8 * TRIES};
        vecs[2] = '{8'h00, NONE, 1, 8'h00, 0,    1'b1, 8 * TRIES};
        vecs[3] = '{8'hFF, 5,    0, 8'hDF, C_DF, 1'b0, 7 * TRIES + 1};
        for (int i = 4; i < 8; i++) begin
            vecs[i].good     = 8'($urandom);
            vecs[i].withhold = ($urandom_range(1, 0) != 0) ? $urandom_range(6, 0) : NONE;
            vecs[i].maxd     = $urandom_range(5, 0);
            vecs[i].exp_mask = vecs[i].good &
                               ~((vecs[i].withhold < NONE) ? (8'd1 << vecs[i].withhold) : 8'd0);
            vecs[i].exp_shift = model_choice(vecs[i].exp_mask);
            vecs[i].exp_fail  = (vecs[i].exp_mask == 8'd0);
            vecs[i].exp_hs    = (vecs[i].withhold < NONE) ? 7 * TRIES + 1 : 8 * TRIES;
        end

        for (int i = 0; i < 8; i++) begin
            run_cal(vecs[i].good, vecs[i].withhold, vecs[i].maxd, -1, i == 0, hs, ab);
            check_result(vecs[i], hs, i);
        end

        // Reset mid-WAIT, then a clean run from scratch.
        run_cal(8'h2C, NONE, 5, 5, 1'b0, hs, ab);
        chk("reset_aborted", {31'd0, ab}, 32'd1);
        repeat (2) @(negedge clock);
        chk("post_reset_idle", {busy, done, fail, rd_req, shift_sel, pass_mask}, 32'd0);
        v = '{8'h2C, NONE, 5, 8'h2C, model_choice(8'h2C), 1'b0, 8 * TRIES};
        run_cal(v.good, v.withhold, v.maxd, -1, 1'b1, hs, ab);
        check_result(v, hs, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
